// File: rtl/cache_pkg.sv
// ============================================================================
// Module      : cache_pkg
// Description : Shared status-bit positions, line geometry and tree-PLRU
//               helpers for the set-associative data cache array.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cache_pkg;

    localparam int STATUS_VALID = 0;
    localparam int STATUS_DIRTY = 1;

    function automatic int line_words(input int offset_len);
        return 1 << (offset_len - 2);
    endfunction

    // Tree layout: bit0 is the root, bit1 covers ways 0/1, bit2 covers ways 2/3.
    function automatic logic [1:0] plru_victim(input logic [2:0] bits, input int ways);
        logic [1:0] v;
        v = 2'b00;
        if (ways == 2) begin
            v = {1'b0, bits[0]};
        end else if (ways == 4) begin
            v = bits[0] ? {1'b1, bits[2]} : {1'b0, bits[1]};
        end
        return v;
    endfunction

    function automatic logic [2:0] plru_update(input logic [2:0] bits, input logic [1:0] way,
                                               input int ways);
        logic [2:0] b;
        b = bits;
        if (ways == 2) begin
            b[0] = ~way[0];
        end else if (ways == 4) begin
            b[0] = ~way[1];
            if (way[1]) b[2] = ~way[0];
            else        b[1] = ~way[0];
        end
        return b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cache_way_ram.sv
// ============================================================================
// Module      : cache_way_ram
// Description : One cache way: {status,tag} RAM plus data line RAM with
//               per-word write enables and a registered read port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_way_ram #(
    parameter int TAG_LEN    = 13,
    parameter int INDEX_LEN  = 10,
    parameter int LINE_WORDS = 4
) (
    input  logic                     clk,
    input  logic                     meta_we_i,
    input  logic [LINE_WORDS-1:0]    data_we_i,
    input  logic [INDEX_LEN-1:0]     wr_index_i,
    input  logic [TAG_LEN-1:0]       wr_tag_i,
    input  logic [2:0]               wr_status_i,
    input  logic [32*LINE_WORDS-1:0] wr_data_i,
    input  logic                     rd_en_i,
    input  logic [INDEX_LEN-1:0]     rd_index_i,
    output logic [TAG_LEN-1:0]       rd_tag_o,
    output logic [2:0]               rd_status_o,
    output logic [32*LINE_WORDS-1:0] rd_data_o
);

    localparam int DEPTH  = 1 << INDEX_LEN;
    localparam int META_W = TAG_LEN + 3;

    logic [META_W-1:0]        meta_mem [DEPTH];
    logic [32*LINE_WORDS-1:0] data_mem [DEPTH];
    logic [META_W-1:0]        rd_meta_q;
    logic [32*LINE_WORDS-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (meta_we_i) begin
            meta_mem[wr_index_i] <= {wr_status_i, wr_tag_i};
        end
        for (int i = 0; i < LINE_WORDS; i++) begin
            if (data_we_i[i]) begin
                data_mem[wr_index_i][i*32 +: 32] <= wr_data_i[i*32 +: 32];
            end
        end
        if (rd_en_i) begin
            rd_meta_q <= meta_mem[rd_index_i];
            rd_data_q <= data_mem[rd_index_i];
        end
    end

    assign rd_tag_o    = rd_meta_q[TAG_LEN-1:0];
    assign rd_status_o = rd_meta_q[META_W-1:TAG_LEN];
    assign rd_data_o   = rd_data_q;

endmodule

`default_nettype wire

// File: rtl/cache_set_ram.sv
// ============================================================================
// Module      : cache_set_ram
// Description : Set-associative tag/data array with tag compare, tree-PLRU
//               victim selection and a one-set-per-cycle reset sweep.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_set_ram
    import cache_pkg::*;
#(
    parameter int  TAG_LEN    = 13,
    parameter int  INDEX_LEN  = 10,
    parameter int  OFFSET_LEN = 4,
    parameter int  WAYS       = 2,
    localparam int LINE_WORDS = line_words(OFFSET_LEN),
    localparam int WAY_W      = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     init_busy,
    input  logic                     req_valid,
    input  logic                     req_we,
    input  logic [INDEX_LEN-1:0]     req_index,
    input  logic [TAG_LEN-1:0]       req_tag,
    input  logic [WAY_W-1:0]         req_way,
    input  logic [2:0]               req_status,
    input  logic [32*LINE_WORDS-1:0] req_wdata,
    input  logic [LINE_WORDS-1:0]    req_wstrb,
    output logic                     rsp_valid,
    output logic                     rsp_hit,
    output logic [WAY_W-1:0]         rsp_way,
    output logic [TAG_LEN-1:0]       rsp_tag,
    output logic [2:0]               rsp_status,
    output logic [32*LINE_WORDS-1:0] rsp_data
);

    localparam int LINE_W = 32 * LINE_WORDS;
    localparam int SETS   = 1 << INDEX_LEN;
    localparam int PLRU_W = (WAYS > 1) ? WAYS - 1 : 1;

    localparam logic [0:0] ST_INIT  = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    logic [0:0]           state_q, state_d;
    logic [INDEX_LEN-1:0] sweep_idx_q, sweep_idx_d;
    logic                 w_init, w_accept, w_wr, w_rd;

    assign w_init    = (state_q == ST_INIT);
    assign init_busy = w_init;
    assign w_accept  = req_valid && !w_init && reset;
    assign w_wr      = w_accept && req_we;
    assign w_rd      = w_accept && !req_we;

    always_comb begin
        state_d     = state_q;
        sweep_idx_d = sweep_idx_q;
        if (state_q == ST_INIT) begin
            sweep_idx_d = sweep_idx_q + 1'b1;
            if (&sweep_idx_q) state_d = ST_READY;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_INIT;
            sweep_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            sweep_idx_q <= sweep_idx_d;
        end
    end

    // The sweep borrows the write port to zero tag/status in every way.
    logic [INDEX_LEN-1:0] w_wr_index;
    logic [TAG_LEN-1:0]   w_wr_tag;
    logic [2:0]           w_wr_status;

    assign w_wr_index  = w_init ? sweep_idx_q : req_index;
    assign w_wr_tag    = w_init ? '0 : req_tag;
    assign w_wr_status = w_init ? 3'b000 : req_status;

    logic [TAG_LEN-1:0] w_rd_tag    [WAYS];
    logic [2:0]         w_rd_status [WAYS];
    logic [LINE_W-1:0]  w_rd_data   [WAYS];

    for (genvar g = 0; g < WAYS; g++) begin : g_way
        logic w_way_wr;
        assign w_way_wr = w_wr && (req_way == WAY_W'(g));

        cache_way_ram #(
            .TAG_LEN    (TAG_LEN),
            .INDEX_LEN  (INDEX_LEN),
            .LINE_WORDS (LINE_WORDS)
        ) u_way_ram (
            .clk         (clk),
            .meta_we_i   (w_init || w_way_wr),
            .data_we_i   (w_way_wr ? req_wstrb : '0),
            .wr_index_i  (w_wr_index),
            .wr_tag_i    (w_wr_tag),
            .wr_status_i (w_wr_status),
            .wr_data_i   (req_wdata),
            .rd_en_i     (w_rd),
            .rd_index_i  (req_index),
            .rd_tag_o    (w_rd_tag[g]),
            .rd_status_o (w_rd_status[g]),
            .rd_data_o   (w_rd_data[g])
        );
    end

    logic                 lk_q;
    logic [INDEX_LEN-1:0] idx_q;
    logic [TAG_LEN-1:0]   tag_q;

    always_ff @(posedge clk) begin
        if (!reset) lk_q <= 1'b0;
        else        lk_q <= w_rd;
    end

    always_ff @(posedge clk) begin
        if (w_rd) begin
            idx_q <= req_index;
            tag_q <= req_tag;
        end
    end

    logic [PLRU_W-1:0] plru_q [SETS];

    logic              w_hit, w_inv;
    logic [WAY_W-1:0]  w_hit_way, w_inv_way, w_sel_way;
    logic [TAG_LEN-1:0] w_sel_tag;
    logic [2:0]        w_sel_status;
    logic [LINE_W-1:0] w_sel_data;

    // Descending scan so the lowest matching / lowest invalid way wins.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        w_inv     = 1'b0;
        w_inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (w_rd_status[w][STATUS_VALID] && (w_rd_tag[w] == tag_q)) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_W'(w);
            end
            if (!w_rd_status[w][STATUS_VALID]) begin
                w_inv     = 1'b1;
                w_inv_way = WAY_W'(w);
            end
        end
        if (w_hit)      w_sel_way = w_hit_way;
        else if (w_inv) w_sel_way = w_inv_way;
        else            w_sel_way = WAY_W'(plru_victim(3'(plru_q[idx_q]), WAYS));
    end

    always_comb begin
        w_sel_tag    = '0;
        w_sel_status = 3'b000;
        w_sel_data   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (WAY_W'(w) == w_sel_way) begin
                w_sel_tag    = w_rd_tag[w];
                w_sel_status = w_rd_status[w];
                w_sel_data   = w_rd_data[w];
            end
        end
    end

    // A write to the same set on the same edge overrides the hit update.
    always_ff @(posedge clk) begin
        if (w_init) begin
            plru_q[sweep_idx_q] <= '0;
        end else begin
            if (lk_q && w_hit) begin
                plru_q[idx_q] <= PLRU_W'(plru_update(3'(plru_q[idx_q]), 2'(w_hit_way), WAYS));
            end
            if (w_wr) begin
                plru_q[req_index] <= PLRU_W'(plru_update(3'(plru_q[req_index]), 2'(req_way), WAYS));
            end
        end
    end

    logic               rsp_valid_q, rsp_hit_q;
    logic [WAY_W-1:0]   rsp_way_q;
    logic [TAG_LEN-1:0] rsp_tag_q;
    logic [2:0]         rsp_status_q;
    logic [LINE_W-1:0]  rsp_data_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            rsp_valid_q  <= 1'b0;
            rsp_hit_q    <= 1'b0;
            rsp_way_q    <= '0;
            rsp_tag_q    <= '0;
            rsp_status_q <= 3'b000;
            rsp_data_q   <= '0;
        end else begin
            rsp_valid_q <= lk_q;
            if (lk_q) begin
                rsp_hit_q    <= w_hit;
                rsp_way_q    <= w_sel_way;
                rsp_tag_q    <= w_sel_tag;
                rsp_status_q <= w_sel_status;
                rsp_data_q   <= w_sel_data;
            end
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_hit    = rsp_hit_q;
    assign rsp_way    = rsp_way_q;
    assign rsp_tag    = rsp_tag_q;
    assign rsp_status = rsp_status_q;
    assign rsp_data   = rsp_data_q;

endmodule

`default_nettype wire

// File: doc/cache_set_ram.md
# cache_set_ram

Set-associative storage array for the data cache: per-way tag/status and data line RAMs plus per-set tree-PLRU state, with tag compare and victim selection. It replaces the direct-mapped tag and data RAM pair. The cache controller issues one lookup or fill per cycle and gets hit/victim information one cycle later. Reset clears the array with a hardware sweep, one set per cycle, not in a single cycle.

## Interface
- TAG_LEN, 13, tag width
- INDEX_LEN, 10, set index width; 2**INDEX_LEN sets
- OFFSET_LEN, 4, byte offset width; LINE_WORDS = 2**(OFFSET_LEN-2) 32-bit words per line
- WAYS, 2, associativity; legal values 1, 2, 4
- WAY_W, derived, max(1, log2(WAYS))

- clk  in  1  clock
- reset  in  1  synchronous, active-low
- init_busy  out  1  sweep in progress; requests ignored
- req_valid  in  1  request strobe; accepted when init_busy=0
- req_we  in  1  1 = fill/write, 0 = lookup
- req_index  in  INDEX_LEN  set
- req_tag  in  TAG_LEN  lookup tag / tag to write
- req_way  in  WAY_W  target way (writes only)
- req_status  in  3  status to write; bit0 = valid, bit1 = dirty
- req_wdata  in  32*LINE_WORDS  line data to write
- req_wstrb  in  LINE_WORDS  per-word write enable; tag/status are always written
- rsp_valid  out  1  lookup result valid (one cycle)
- rsp_hit  out  1  tag matched a valid way
- rsp_way  out  WAY_W  hit way, else victim way
- rsp_tag  out  TAG_LEN  tag stored in rsp_way
- rsp_status  out  3  status stored in rsp_way
- rsp_data  out  32*LINE_WORDS  line stored in rsp_way

## Operation
- Reset low in any cycle:
  - the sweep counter goes to 0 and init_busy goes to 1;
  - the pending response is cancelled;
  - reset values: rsp_valid=0, rsp_hit=0, rsp_way=0, rsp_tag=0, rsp_status=0, rsp_data=0.
- Sweep, states INIT and READY:
  - In INIT, each cycle writes tag=0 and status=0 to every way of set sweep_idx, and PLRU=0 for that set.
  - The data arrays are not cleared.
  - After set 2**INDEX_LEN-1 the block moves to READY and init_busy=0.
  - Reset during INIT restarts the sweep at 0.
- Lookup (req_valid, !req_we):
  - Hit: some way has status[0]=1 and a matching tag. rsp_way is the lowest such way.
  - Miss: the victim is the lowest invalid way; if all ways are valid, the PLRU victim.
  - The rsp_* fields report the contents of rsp_way.
  - A hit marks rsp_way most-recently-used. A miss leaves PLRU unchanged.
- Write (req_valid, req_we):
  - Writes tag/status to req_way, and data words where req_wstrb[i]=1.
  - Marks req_way MRU.
  - No response is produced.
- PLRU: binary tree of WAYS-1 bits per set, where bit=0 points left; WAYS=1 uses no state and the victim is always 0.
- Collision: a hit update and a write to the same set land on the same edge. The write's MRU update wins.

## Timing
- Lookup accepted at edge N: rsp_valid=1 and all rsp_* fields valid after edge N+1.
- rsp_* fields hold until the next accepted lookup. rsp_valid is high for one cycle only.
- Write at edge N is visible to a lookup accepted at edge N+1 (read-after-write, no bypass needed).
- Full throughput: one request per cycle, back-to-back lookups allowed.
- Sweep length is exactly 2**INDEX_LEN cycles after reset is released.
- Requests with init_busy=1 are dropped: no state change, no response.

## Structure
- Package cache_pkg holds:
  - STATUS_VALID=0 and STATUS_DIRTY=1 bit positions;
  - the LINE_WORDS function;
  - PLRU victim/update functions.
- Sub-module cache_way_ram, one per way, with a generate loop:
  - one block RAM for {status, tag} and one for the data line;
  - per-word write enables;
  - registered read.
- PLRU bits, sweep FSM, tag compare and output mux live in the top level.

## Test plan
- INDEX_LEN=4: release reset → init_busy=1 for exactly 16 cycles; then a lookup at index 3 gives rsp_hit=0, rsp_status=0, rsp_way=0.
- Write way 1, index 5, tag 0x123, status 3'b001, wstrb 4'b1111, data 0x…4444_3333_2222_1111; next-cycle lookup of index 5, tag 0x123 → rsp_valid=1, hit=1, way=1, data matches.
- Write to that line with wstrb 4'b0100 and word2=0xDEADBEEF → lookup returns word2=0xDEADBEEF, other words unchanged, status unchanged if rewritten as 3'b001.
- WAYS=2: fill ways 0 and 1 at index 9; hit way 0; then lookup a missing tag → hit=0, way=1, returning way 1's tag/data. Hit way 1, miss again → way=0.
- Write index 2, pull reset low at sweep index 7 → sweep restarts and init_busy stays high another 16 cycles; the index-2 lookup then misses.
- req_valid during init_busy → no rsp_valid, and the array is unchanged after the sweep.
